tile_seq: RTL and testbench

TILE_SEQ -- requirements
Module: tile_seq

---
 rtl/tile_seq_pkg.sv | 21 ++
 rtl/tile_addr_gen.sv | 115 +++++++++++
 rtl/tile_seq.sv | 186 ++++++++++++++++++
 tb/tb_tile_seq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_seq_pkg.sv
// tile_seq_pkg -- shared definitions for the tile sequencer.
//   state_e    : sequencer FSM states
//   tile_cnt_w : bit width of a tile-count port for a given MAX_TILES
//                (must be able to represent MAX_TILES itself, hence +1)
package tile_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRAIN,
    COMPUTE,
    WAIT_OUT,
    ADVANCE,
    FINISH
  } state_e;

  function automatic int tile_cnt_w(input int max_tiles);
    return $clog2(max_tiles) + 1;
  endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen -- m/k/n tile indices and the three per-tile row-address
// accumulators for tile_seq. Addresses only ever move by constant or
// per-job strides, so no runtime multiplier is needed.
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   load             capture counts/bases and rewind to tile (0,0,0)
//   step             advance m (inner), then k, then n (outer)
//   *_tiles, *_base  job configuration, sampled on load
//   m_last/k_last/n_last  current index is the final one in its dimension
//   accumulate       0 on the first k tile of an output tile
//   weight/input/output_addr  current tile base rows (mod 2^ADDR_WIDTH)
module tile_addr_gen
  import tile_seq_pkg::*;
#(
  parameter int WIDTH_HEIGHT = 16,
  parameter int MAX_TILES    = 8,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                load,
  input  logic                                step,
  input  logic [tile_cnt_w(MAX_TILES)-1:0]    m_tiles,
  input  logic [tile_cnt_w(MAX_TILES)-1:0]    k_tiles,
  input  logic [tile_cnt_w(MAX_TILES)-1:0]    n_tiles,
  input  logic [ADDR_WIDTH-1:0]               input_base,
  input  logic [ADDR_WIDTH-1:0]               weight_base,
  input  logic [ADDR_WIDTH-1:0]               output_base,
  output logic                                m_last,
  output logic                                k_last,
  output logic                                n_last,
  output logic                                accumulate,
  output logic [ADDR_WIDTH-1:0]               weight_addr,
  output logic [ADDR_WIDTH-1:0]               input_addr,
  output logic [ADDR_WIDTH-1:0]               output_addr
);

  localparam int CW = tile_cnt_w(MAX_TILES);
  localparam logic [ADDR_WIDTH-1:0] TILE_ROWS = ADDR_WIDTH'(WIDTH_HEIGHT);

  logic [CW-1:0]         m_idx, k_idx, n_idx;
  logic [CW-1:0]         m_end, k_end, n_end;
  logic [ADDR_WIDTH-1:0] in_stride;   // k_tiles*WIDTH_HEIGHT: next m, same k
  logic [ADDR_WIDTH-1:0] out_stride;  // n_tiles*WIDTH_HEIGHT: next m, same n
  logic [ADDR_WIDTH-1:0] in_base_q;
  logic [ADDR_WIDTH-1:0] in_k_base;   // input address of tile (m=0, k)
  logic [ADDR_WIDTH-1:0] out_n_base;  // output address of tile (m=0, n)

  assign m_last     = (m_idx == m_end);
  assign k_last     = (k_idx == k_end);
  assign n_last     = (n_idx == n_end);
  assign accumulate = (k_idx != '0);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates in one edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_idx       <= '0;
      k_idx       <= '0;
      n_idx       <= '0;
      m_end       <= '0;
      k_end       <= '0;
      n_end       <= '0;
      in_stride   <= '0;
      out_stride  <= '0;
      in_base_q   <= '0;
      in_k_base   <= '0;
      out_n_base  <= '0;
      weight_addr <= '0;
      input_addr  <= '0;
      output_addr <= '0;
    end else if (load) begin
      m_idx       <= '0;
      k_idx       <= '0;
      n_idx       <= '0;
      m_end       <= m_tiles - CW'(1);
      k_end       <= k_tiles - CW'(1);
      n_end       <= n_tiles - CW'(1);
      // Constant-factor scaling, done once per job.
      in_stride   <= ADDR_WIDTH'(int'(k_tiles) * WIDTH_HEIGHT);
      out_stride  <= ADDR_WIDTH'(int'(n_tiles) * WIDTH_HEIGHT);
      in_base_q   <= input_base;
      in_k_base   <= input_base;
      out_n_base  <= output_base;
      weight_addr <= weight_base;
      input_addr  <= input_base;
      output_addr <= output_base;
    end else if (step) begin
      if (!m_last) begin
        m_idx       <= m_idx + CW'(1);
        input_addr  <= input_addr + in_stride;
        output_addr <= output_addr + out_stride;
      end else begin
        // Weight tiles are visited in storage order (n-major, k-minor),
        // so each new weight tile is simply the next one.
        m_idx       <= '0;
        weight_addr <= weight_addr + TILE_ROWS;
        if (!k_last) begin
          k_idx       <= k_idx + CW'(1);
          in_k_base   <= in_k_base + TILE_ROWS;
          input_addr  <= in_k_base + TILE_ROWS;
          output_addr <= out_n_base;
        end else begin
          k_idx       <= '0;
          n_idx       <= n_idx + CW'(1);
          in_k_base   <= in_base_q;
          input_addr  <= in_base_q;
          out_n_base  <= out_n_base + TILE_ROWS;
          output_addr <= out_n_base + TILE_ROWS;
        end
      end
    end
  end

endmodule

// File: rtl/tile_seq.sv
// tile_seq -- tiled matrix-multiply sequencer for a WIDTH_HEIGHT systolic
// array. Walks n (outer), k, m (inner) tiles, issuing fill/drain commands
// once per weight tile and an active pulse per (m,k,n) tile.
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   start, abort         job start pulse (accepted only when idle), abort
//   m/k/n_tiles          tile counts (1..MAX_TILES), sampled on start
//   input/weight/output_base  base rows, sampled on start
//   mem_to_fifo_done, fifo_to_arr_done, output_done  controller completions
//   fill_fifo, drain_fifo, active  one-cycle command pulses
//   *_addr_base          current tile base rows
//   accumulate           0 = overwrite (first k tile), 1 = add
//   busy, done, err      status; err is sticky until the next start
//   cycle_count          only with TILE_SEQ_PERF_CNT_EN: busy-cycle counter
module tile_seq
  import tile_seq_pkg::*;
#(
  parameter int WIDTH_HEIGHT = 16,
  parameter int MAX_TILES    = 8,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [tile_cnt_w(MAX_TILES)-1:0] m_tiles,
  input  logic [tile_cnt_w(MAX_TILES)-1:0] k_tiles,
  input  logic [tile_cnt_w(MAX_TILES)-1:0] n_tiles,
  input  logic [ADDR_WIDTH-1:0]            input_base,
  input  logic [ADDR_WIDTH-1:0]            weight_base,
  input  logic [ADDR_WIDTH-1:0]            output_base,
  input  logic                             mem_to_fifo_done,
  input  logic                             fifo_to_arr_done,
  input  logic                             output_done,
  output logic                             fill_fifo,
  output logic                             drain_fifo,
  output logic                             active,
  output logic [ADDR_WIDTH-1:0]            weight_rd_addr_base,
  output logic [ADDR_WIDTH-1:0]            input_rd_addr_base,
  output logic [ADDR_WIDTH-1:0]            output_wr_addr_base,
  output logic                             accumulate,
  output logic                             busy,
  output logic                             done,
  output logic                             err
`ifdef TILE_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                      cycle_count
`endif
);

  localparam int CW = tile_cnt_w(MAX_TILES);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TILES);

  state_e state_q, state_d;
  logic   fill_d, drain_d, active_d, done_d, err_d;
  logic   load, step;
  logic   m_last, k_last, n_last;
  logic   counts_ok;

  assign counts_ok = (m_tiles != '0) && (m_tiles <= MAX_CNT) &&
                     (k_tiles != '0) && (k_tiles <= MAX_CNT) &&
                     (n_tiles != '0) && (n_tiles <= MAX_CNT);

  assign busy = (state_q != IDLE);

  // Command pulses are registered so each one coincides with the first
  // cycle of the state it opens.
  // NOTE: every output of this block gets a default first; any path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    fill_d   = 1'b0;
    drain_d  = 1'b0;
    active_d = 1'b0;
    done_d   = 1'b0;
    err_d    = err;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        if (counts_ok) begin
          state_d = FILL;
          fill_d  = 1'b1;
          load    = 1'b1;
          err_d   = 1'b0;
        end else begin
          state_d = FINISH;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      FILL: if (mem_to_fifo_done) begin
        state_d = DRAIN;
        drain_d = 1'b1;
      end
      DRAIN: if (fifo_to_arr_done) begin
        state_d  = COMPUTE;
        active_d = 1'b1;
      end
      COMPUTE: state_d = WAIT_OUT;
      WAIT_OUT: if (output_done) state_d = ADVANCE;
      ADVANCE: begin
        if (!m_last) begin
          state_d  = COMPUTE;
          active_d = 1'b1;
          step     = 1'b1;
        end else if (!(k_last && n_last)) begin
          state_d = FILL;
          fill_d  = 1'b1;
          step    = 1'b1;
        end else begin
          state_d = FINISH;
          done_d  = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever the state would otherwise do this cycle.
    if (abort && (state_q inside {FILL, DRAIN, COMPUTE, WAIT_OUT, ADVANCE})) begin
      state_d  = FINISH;
      fill_d   = 1'b0;
      drain_d  = 1'b0;
      active_d = 1'b0;
      step     = 1'b0;
      done_d   = 1'b1;
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      fill_fifo  <= 1'b0;
      drain_fifo <= 1'b0;
      active     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_fifo  <= fill_d;
      drain_fifo <= drain_d;
      active     <= active_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  tile_addr_gen #(
    .WIDTH_HEIGHT(WIDTH_HEIGHT),
    .MAX_TILES   (MAX_TILES),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .m_tiles    (m_tiles),
    .k_tiles    (k_tiles),
    .n_tiles    (n_tiles),
    .input_base (input_base),
    .weight_base(weight_base),
    .output_base(output_base),
    .m_last     (m_last),
    .k_last     (k_last),
    .n_last     (n_last),
    .accumulate (accumulate),
    .weight_addr(weight_rd_addr_base),
    .input_addr (input_rd_addr_base),
    .output_addr(output_wr_addr_base)
  );

`ifdef TILE_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (start && (state_q == IDLE)) begin
      cycle_count <= '0;
    end else if (busy && (cycle_count != '1)) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tile_seq.sv
// tb_tile_seq -- self-checking bench for tile_seq (default parameters).
// A responder answers each command after a random latency, optionally
// injecting done pulses the sequencer is not waiting for; a monitor logs
// every command. Expected command streams come from a nested-loop model
// of the tile walk. Build with TILE_SEQ_PERF_CNT_EN to cover cycle_count.
module tb_tile_seq;

  localparam int WH = 16;
  localparam int MT = 8;
  localparam int AW = 8;
  localparam int CW = $clog2(MT) + 1;

  logic          clk, reset, start, abort;
  logic [CW-1:0] m_tiles, k_tiles, n_tiles;
  logic [AW-1:0] input_base, weight_base, output_base;
  logic          mem_to_fifo_done, fifo_to_arr_done, output_done;
  logic          fill_fifo, drain_fifo, active, accumulate, busy, done, err;
  logic [AW-1:0] weight_rd_addr_base, input_rd_addr_base, output_wr_addr_base;
`ifdef TILE_SEQ_PERF_CNT_EN
  logic [31:0]   cycle_count;
`endif

  tile_seq #(.WIDTH_HEIGHT(WH), .MAX_TILES(MT), .ADDR_WIDTH(AW)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .abort              (abort),
    .m_tiles            (m_tiles),
    .k_tiles            (k_tiles),
    .n_tiles            (n_tiles),
    .input_base         (input_base),
    .weight_base        (weight_base),
    .output_base        (output_base),
    .mem_to_fifo_done   (mem_to_fifo_done),
    .fifo_to_arr_done   (fifo_to_arr_done),
    .output_done        (output_done),
    .fill_fifo          (fill_fifo),
    .drain_fifo         (drain_fifo),
    .active             (active),
    .weight_rd_addr_base(weight_rd_addr_base),
    .input_rd_addr_base (input_rd_addr_base),
    .output_wr_addr_base(output_wr_addr_base),
    .accumulate         (accumulate),
    .busy               (busy),
    .done               (done),
    .err                (err)
`ifdef TILE_SEQ_PERF_CNT_EN
    ,
    .cycle_count        (cycle_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [AW-1:0]   obs_fill[$];
  logic [AW-1:0]   obs_drain[$];
  logic [2*AW:0]   obs_act[$];   // {input addr, output addr, accumulate}
  logic            obs_done[$];  // err value at each done pulse
  int              busy_cycles;

  initial forever begin
    @(negedge clk);
    if (fill_fifo)  obs_fill.push_back(weight_rd_addr_base);
    if (drain_fifo) obs_drain.push_back(weight_rd_addr_base);
    if (active)     obs_act.push_back({input_rd_addr_base, output_wr_addr_base, accumulate});
    if (done)       obs_done.push_back(err);
    if (busy)       busy_cycles++;
  end

  function automatic void clear_obs();
    obs_fill.delete();
    obs_drain.delete();
    obs_act.delete();
    obs_done.delete();
    busy_cycles = 0;
  endfunction

  // ---------------- responder ----------------
  bit resp_en    = 1'b0;
  bit resp_noise = 1'b0;
  int resp_lat   = 1;

  initial begin
    int cd_f, cd_d, cd_o;
    cd_f = 0; cd_d = 0; cd_o = 0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        mem_to_fifo_done = 1'b0;
        fifo_to_arr_done = 1'b0;
        output_done      = 1'b0;
        if (cd_f > 0) begin cd_f--; if (cd_f == 0) mem_to_fifo_done = 1'b1; end
        if (cd_d > 0) begin cd_d--; if (cd_d == 0) fifo_to_arr_done = 1'b1; end
        if (cd_o > 0) begin cd_o--; if (cd_o == 0) output_done      = 1'b1; end
        if (fill_fifo)  cd_f = resp_lat;
        if (drain_fifo) cd_d = resp_lat;
        if (active)     cd_o = resp_lat;
        // Stray completions only while nothing of that kind is outstanding,
        // i.e. while the sequencer is in a state that must ignore them.
        if (resp_noise) begin
          if (cd_f == 0 && $urandom_range(0, 7) == 0) mem_to_fifo_done = 1'b1;
          if (cd_d == 0 && $urandom_range(0, 7) == 0) fifo_to_arr_done = 1'b1;
          if (cd_o == 0 && $urandom_range(0, 7) == 0) output_done      = 1'b1;
        end
      end else begin
        cd_f = 0; cd_d = 0; cd_o = 0;
      end
    end
  end

  function automatic logic [31:0] all_outs();
    return {1'b0, fill_fifo, drain_fifo, active, accumulate, busy, done, err,
            weight_rd_addr_base, input_rd_addr_base, output_wr_addr_base};
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return fill_fifo;
      1:       return drain_fifo;
      2:       return active;
      default: return done;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sig(sel)) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic do_start(input int m, input int k, input int n,
                          input logic [AW-1:0] ib, input logic [AW-1:0] wb,
                          input logic [AW-1:0] ob);
    @(negedge clk);
    m_tiles = CW'(m); k_tiles = CW'(k); n_tiles = CW'(n);
    input_base = ib; weight_base = wb; output_base = ob;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs a complete job through the responder and compares the observed
  // command streams with the tile-walk model.
  task automatic run_job(input int m, input int k, input int n,
                         input logic [AW-1:0] ib, input logic [AW-1:0] wb,
                         input logic [AW-1:0] ob, input int lat, input bit noise);
    logic [AW-1:0] e_fill[$];
    logic [2*AW:0] e_act[$];
    int cyc;
    for (int nn = 0; nn < n; nn++)
      for (int kk = 0; kk < k; kk++) begin
        e_fill.push_back(AW'(int'(wb) + (nn * k + kk) * WH));
        for (int mm = 0; mm < m; mm++)
          e_act.push_back({AW'(int'(ib) + (mm * k + kk) * WH),
                           AW'(int'(ob) + (mm * n + nn) * WH), (kk != 0)});
      end
    clear_obs();
    resp_lat = lat; resp_noise = noise; resp_en = 1'b1;
    do_start(m, k, n, ib, wb, ob);
    check("start_fill", 32'(fill_fifo), 32'd1);
    check("start_err_clr", 32'(err), 32'd0);
    cyc = 0;
    while (obs_done.size() == 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      // A start while busy must leave the running job untouched.
      if (cyc == 3) begin
        start = 1'b1;
        m_tiles = CW'($urandom); k_tiles = CW'($urandom); n_tiles = CW'($urandom);
        input_base = AW'($urandom); weight_base = AW'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("job_done_seen", 32'(obs_done.size() != 0), 32'd1);
    repeat (3) @(negedge clk);
    check("n_fill",  32'(obs_fill.size()),  32'(e_fill.size()));
    check("n_drain", 32'(obs_drain.size()), 32'(e_fill.size()));
    check("n_act",   32'(obs_act.size()),   32'(e_act.size()));
    check("n_done",  32'(obs_done.size()),  32'd1);
    if (obs_done.size() != 0) check("job_err", 32'(obs_done[0]), 32'd0);
    check("job_idle", 32'(busy), 32'd0);
    for (int i = 0; i < e_fill.size() && i < obs_fill.size(); i++)
      check($sformatf("fill_addr[%0d]", i), 32'(obs_fill[i]), 32'(e_fill[i]));
    for (int i = 0; i < e_fill.size() && i < obs_drain.size(); i++)
      check($sformatf("drain_addr[%0d]", i), 32'(obs_drain[i]), 32'(e_fill[i]));
    for (int i = 0; i < e_act.size() && i < obs_act.size(); i++)
      check($sformatf("act[%0d]", i), 32'(obs_act[i]), 32'(e_act[i]));
    resp_en = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] exp_in[4];
    logic [AW-1:0] exp_out[4];
    logic          exp_acc[4];
    exp_in  = '{8'd0, 8'd32, 8'd16, 8'd48};
    exp_out = '{8'd0, 8'd16, 8'd0, 8'd16};
    exp_acc = '{1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b0; start = 1'b0; abort = 1'b0;
    m_tiles = '0; k_tiles = '0; n_tiles = '0;
    input_base = '0; weight_base = '0; output_base = '0;
    mem_to_fifo_done = 1'b0; fifo_to_arr_done = 1'b0; output_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", all_outs(), 32'd0);
`ifdef TILE_SEQ_PERF_CNT_EN
    check("rst_cycle_count", cycle_count, 32'd0);
`endif
    reset = 1'b1;

    // Smallest job.
    run_job(1, 1, 1, 8'd0, 8'd0, 8'd0, 1, 1'b0);
    if (obs_act.size() == 1) check("j111_act", 32'(obs_act[0]), 32'd0);
    if (obs_fill.size() == 1) check("j111_waddr", 32'(obs_fill[0]), 32'd0);

    // 2x2x1 directed address / accumulate sequence.
    run_job(2, 2, 1, 8'd0, 8'd0, 8'd0, 2, 1'b0);
    check("j221_fills", 32'(obs_fill.size()), 32'd2);
    for (int i = 0; i < 4 && i < obs_act.size(); i++) begin
      check($sformatf("j221_in[%0d]", i),  32'(obs_act[i][2*AW:AW+1]), 32'(exp_in[i]));
      check($sformatf("j221_out[%0d]", i), 32'(obs_act[i][AW:1]),      32'(exp_out[i]));
      check($sformatf("j221_acc[%0d]", i), 32'(obs_act[i][0]),         32'(exp_acc[i]));
    end

    // Invalid counts: zero and above MAX_TILES.
    for (int t = 0; t < 2; t++) begin
      resp_en = 1'b0;
      clear_obs();
      if (t == 0) do_start(1, 0, 1, 8'd5, 8'd5, 8'd5);
      else        do_start(MT + 1, 2, 2, 8'd5, 8'd5, 8'd5);
      check($sformatf("bad%0d_done", t), 32'(done), 32'd1);
      check($sformatf("bad%0d_err", t),  32'(err),  32'd1);
      check($sformatf("bad%0d_fill", t), 32'(fill_fifo), 32'd0);
      @(negedge clk);
      check($sformatf("bad%0d_idle", t),   32'(busy), 32'd0);
      check($sformatf("bad%0d_sticky", t), 32'(err),  32'd1);
      repeat (3) @(negedge clk);
      check($sformatf("bad%0d_nofill", t), 32'(obs_fill.size()), 32'd0);
      check($sformatf("bad%0d_ndone", t),  32'(obs_done.size()), 32'd1);
    end

    // Abort in WAIT_OUT together with output_done: abort wins.
    resp_en = 1'b0;
    clear_obs();
    do_start(2, 1, 1, 8'd0, 8'd0, 8'd0);
    wait_sig(0, "ab_fill");
    mem_to_fifo_done = 1'b1; @(negedge clk); mem_to_fifo_done = 1'b0;
    wait_sig(1, "ab_drain");
    fifo_to_arr_done = 1'b1; @(negedge clk); fifo_to_arr_done = 1'b0;
    wait_sig(2, "ab_active");
    @(negedge clk);
    abort = 1'b1; output_done = 1'b1;
    @(negedge clk);
    abort = 1'b0; output_done = 1'b0;
    check("ab_done", 32'(done), 32'd1);
    check("ab_err",  32'(err),  32'd1);
    repeat (6) @(negedge clk);
    check("ab_n_act",  32'(obs_act.size()),  32'd1);
    check("ab_n_fill", 32'(obs_fill.size()), 32'd1);
    check("ab_n_done", 32'(obs_done.size()), 32'd1);
    check("ab_idle",   32'(busy), 32'd0);

    // Reset in the middle of DRAIN, then a fresh job.
    clear_obs();
    do_start(2, 2, 2, 8'd7, 8'd9, 8'd11);
    wait_sig(0, "rm_fill");
    mem_to_fifo_done = 1'b1; @(negedge clk); mem_to_fifo_done = 1'b0;
    wait_sig(1, "rm_drain");
    reset = 1'b0;
    @(negedge clk);
    check("rm_outs", all_outs(), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rm_no_done", 32'(obs_done.size()), 32'd0);
    run_job(2, 2, 2, 8'd3, 8'd200, 8'd250, 1, 1'b1);

    // Largest job, exercises address wrap.
    run_job(MT, MT, MT, 8'd17, 8'd129, 8'd240, 1, 1'b1);

    // Random jobs.
    for (int j = 0; j < 10; j++)
      run_job($urandom_range(1, 4), $urandom_range(1, MT), $urandom_range(1, 4),
              AW'($urandom), AW'($urandom), AW'($urandom),
              $urandom_range(1, 4), 1'($urandom_range(0, 1)));

`ifdef TILE_SEQ_PERF_CNT_EN
    // 1x1x1 with every completion 3 cycles after its command:
    // FILL 4 + DRAIN 4 + COMPUTE 1 + WAIT_OUT 3 + ADVANCE 1 + FINISH 1.
    run_job(1, 1, 1, 8'd0, 8'd0, 8'd0, 3, 1'b0);
    check("perf_count",  cycle_count, 32'd14);
    check("perf_vs_busy", cycle_count, 32'(busy_cycles));
    repeat (4) @(negedge clk);
    check("perf_hold", cycle_count, 32'd14);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
